// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage F/D/E/M/W ARM pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWD,
    input  logic             MemtoRegD,
    input  logic             PCSD,
    input  logic             CondExE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [REG_W-1:0] PC_TAG = REG_W'(PC_REG);

    logic [REG_W-1:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
    logic             regw_e_q, regw_e_d, mem_e_q, mem_e_d, pcs_e_q, pcs_e_d;
    logic [REG_W-1:0] wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
    logic             regw_m_q, regw_m_d, pcs_m_q, pcs_m_d;
    logic             regw_w_q, regw_w_d, pcs_w_q, pcs_w_d;

    logic       ldr_stall, pc_wr_pend;
    logic       stall_fet, stall_dec, flush_dec, flush_ex;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] ra,
        input logic             regw_m,
        input logic [REG_W-1:0] wa3_m,
        input logic             regw_w,
        input logic [REG_W-1:0] wa3_w
    );
        if (ra == PC_TAG)                 return 2'b00;
        if (regw_m && (wa3_m == ra))      return 2'b10;
        if (regw_w && (wa3_w == ra))      return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ldr_stall  = mem_e_q && regw_e_q && ((wa3_e_q == RA1D) || (wa3_e_q == RA2D));
        pc_wr_pend = PCSD | pcs_e_q | pcs_m_q;
        stall_fet  = ldr_stall | pc_wr_pend;
        stall_dec  = ldr_stall;
        flush_ex   = ldr_stall | BranchTakenE;
        flush_dec  = pc_wr_pend | pcs_w_q | BranchTakenE;
        fwd_a      = fwd_sel(ra1_e_q, regw_m_q, wa3_m_q, regw_w_q, wa3_w_q);
        fwd_b      = fwd_sel(ra2_e_q, regw_m_q, wa3_m_q, regw_w_q, wa3_w_q);
    end

    // A flushed D/E register becomes a bubble; M inherits only condition-passing writes.
    always_comb begin
        ra1_e_d  = flush_ex ? '0   : RA1D;
        ra2_e_d  = flush_ex ? '0   : RA2D;
        wa3_e_d  = flush_ex ? '0   : WA3D;
        regw_e_d = flush_ex ? 1'b0 : RegWD;
        mem_e_d  = flush_ex ? 1'b0 : MemtoRegD;
        pcs_e_d  = flush_ex ? 1'b0 : PCSD;
        wa3_m_d  = wa3_e_q;
        regw_m_d = regw_e_q & CondExE;
        pcs_m_d  = pcs_e_q & CondExE;
        wa3_w_d  = wa3_m_q;
        regw_w_d = regw_m_q;
        pcs_w_d  = pcs_m_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e_q  <= '0;
            ra2_e_q  <= '0;
            wa3_e_q  <= '0;
            regw_e_q <= 1'b0;
            mem_e_q  <= 1'b0;
            pcs_e_q  <= 1'b0;
            wa3_m_q  <= '0;
            regw_m_q <= 1'b0;
            pcs_m_q  <= 1'b0;
            wa3_w_q  <= '0;
            regw_w_q <= 1'b0;
            pcs_w_q  <= 1'b0;
        end else begin
            ra1_e_q  <= ra1_e_d;
            ra2_e_q  <= ra2_e_d;
            wa3_e_q  <= wa3_e_d;
            regw_e_q <= regw_e_d;
            mem_e_q  <= mem_e_d;
            pcs_e_q  <= pcs_e_d;
            wa3_m_q  <= wa3_m_d;
            regw_m_q <= regw_m_d;
            pcs_m_q  <= pcs_m_d;
            wa3_w_q  <= wa3_w_d;
            regw_w_q <= regw_w_d;
            pcs_w_q  <= pcs_w_d;
        end
    end

    // Every control output reads as 0 while reset is held.
    assign ForwardAE = reset ? fwd_a : 2'b00;
    assign ForwardBE = reset ? fwd_b : 2'b00;
    assign StallF    = reset & stall_fet;
    assign StallD    = reset & stall_dec;
    assign FlushD    = reset & flush_dec;
    assign FlushE    = reset & flush_ex;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v)) return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, ldr_stall);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_dec | flush_ex);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; honours HAZARD_PERF_EN for counter checks.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } exp_t;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
        logic       regw;
        logic       mem;
        logic       pcs;
        logic       cond;
        logic       br;
        exp_t       e;
    } stim_t;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        RegWD, MemtoRegD, PCSD, CondExE, BranchTakenE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] StallCnt, FlushCnt;

    int   checks;
    int   errors;
    int   m_stall;
    int   m_flush;
    exp_t exp_q[$];

    pipeline_hazard_ctrl #(.REG_W(4), .PC_REG(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWD(RegWD), .MemtoRegD(MemtoRegD), .PCSD(PCSD),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(
        input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
        input logic regw, input logic mem, input logic pcs, input logic cond, input logic br,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic sf, input logic sd, input logic fd, input logic fe);
        stim_t s;
        s.ra1 = ra1; s.ra2 = ra2; s.wa3 = wa3;
        s.regw = regw; s.mem = mem; s.pcs = pcs; s.cond = cond; s.br = br;
        s.e = '{fa: fa, fb: fb, sf: sf, sd: sd, fd: fd, fe: fe};
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction

    function automatic logic [15:0] exp_cnt(input int m);
        if (!PERF) return 16'h0;
        if (m > 65535) return 16'hFFFF;
        return 16'(m);
    endfunction

    function automatic exp_t observed();
        return '{fa: ForwardAE, fb: ForwardBE, sf: StallF, sd: StallD, fd: FlushD, fe: FlushE};
    endfunction

    task automatic zero_inputs();
        RA1D = 0; RA2D = 0; WA3D = 0;
        RegWD = 0; MemtoRegD = 0; PCSD = 0; CondExE = 1; BranchTakenE = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        RA1D = s.ra1; RA2D = s.ra2; WA3D = s.wa3;
        RegWD = s.regw; MemtoRegD = s.mem; PCSD = s.pcs;
        CondExE = s.cond; BranchTakenE = s.br;
        exp_q.push_back(s.e);
        if (s.e.sd) m_stall++;
        if (s.e.fd | s.e.fe) m_flush++;
    endtask

    task automatic test_reset();
        exp_t e, got;
        reset = 1'b0;
        RA1D = 1; RA2D = 1; WA3D = 1;
        RegWD = 1; MemtoRegD = 1; PCSD = 1; CondExE = 1; BranchTakenE = 1;
        exp_q.push_back('0);
        #3;
        got = observed();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", got, e);
        end
        checks++;
        if (StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters got stall=%0d flush=%0d exp 0 0", StallCnt, FlushCnt);
        end
        do_reset();
    endtask

    task automatic test_forward_m();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 5, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0));
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL forward_m[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_forward_w();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(0, 7, 6, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 5, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0));
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL forward_w[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 0));
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1));
        tab.push_back(mk(1, 1, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(nop());
        tab[3].e.fa = 2'b01;
        tab[3].e.fb = 2'b01;
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== exp_cnt(m_stall) || FlushCnt !== exp_cnt(m_flush)) begin
            errors++;
            $display("FAIL load_use_cnt got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     StallCnt, FlushCnt, exp_cnt(m_stall), exp_cnt(m_flush));
        end
    endtask

    task automatic test_branch();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(nop());
        tab.push_back(mk(1, 5, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1));
        tab.push_back(nop());
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, e);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== exp_cnt(m_stall) || FlushCnt !== exp_cnt(m_flush)) begin
            errors++;
            $display("FAIL branch_cnt got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     StallCnt, FlushCnt, exp_cnt(m_stall), exp_cnt(m_flush));
        end
    endtask

    task automatic test_pc_write();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 3, 15, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0));
        tab.push_back(nop());
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pc_write[%0d] got=%b exp=%b", i, got, e);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== exp_cnt(m_stall) || FlushCnt !== exp_cnt(m_flush)) begin
            errors++;
            $display("FAIL pc_write_cnt got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     StallCnt, FlushCnt, exp_cnt(m_stall), exp_cnt(m_flush));
        end
    endtask

    task automatic test_squash();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(2, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(nop());
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL squash[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_r15_source();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 0, 15, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(15, 15, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(15, 15, 5, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL r15_source[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_ldr_pc();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 0, 15, 1, 1, 1, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        tab.push_back(mk(15, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 1, 1));
        tab.push_back(mk(15, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ldr_pc[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_ldr_branch();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 2, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 1, 1));
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ldr_branch[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t tab[$];
        exp_t  e, got;
        do_reset();
        tab.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1));
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_stall[%0d] got=%b exp=%b", i, got, e);
            end
        end
        #1;
        reset = 1'b0;
        BranchTakenE = 1'b1;
        PCSD = 1'b1;
        exp_q.push_back('0);
        #1;
        got = observed();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_stall_reset got=%b exp=%b", got, e);
        end
        checks++;
        if (StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_stall_reset_cnt got stall=%0d flush=%0d exp 0 0", StallCnt, FlushCnt);
        end
        #1;
        BranchTakenE = 1'b0;
        PCSD = 1'b0;
        reset = 1'b1;
        m_stall = 0;
        m_flush = 0;
        tab.delete();
        tab.push_back(mk(1, 1, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tab.push_back(nop());
        foreach (tab[i]) begin
            apply(tab[i]);
            @(negedge clk);
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL post_reset[%0d] got=%b exp=%b", i, got, e);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (StallCnt !== exp_cnt(m_stall) || FlushCnt !== exp_cnt(m_flush)) begin
            errors++;
            $display("FAIL post_reset_cnt got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     StallCnt, FlushCnt, exp_cnt(m_stall), exp_cnt(m_flush));
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_saturation();
        do_reset();
        BranchTakenE = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if (FlushCnt !== 16'hFFFF || StallCnt !== 16'h0) begin
            errors++;
            $display("FAIL saturation got flush=%h stall=%h exp flush=ffff stall=0000", FlushCnt, StallCnt);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (FlushCnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_hold got flush=%h exp ffff", FlushCnt);
        end
        BranchTakenE = 1'b0;
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        m_stall = 0;
        m_flush = 0;
        zero_inputs();
        reset = 1'b0;
        test_reset();
        test_forward_m();
        test_forward_w();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_pc_write();
        test_squash();
        test_r15_source();
        test_ldr_pc();
        test_ldr_branch();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
